// File: rtl/sw_out_arb.sv
`timescale 1ns/1ps
// sw_out_arb: per-output-port round-robin arbiter with wormhole lock for the 4-port switch.
// Grants one input whose head flit targets PORT_ID and forwards its flits until the tail or a timeout.
module sw_out_arb #(
    parameter int PORT_ID = 0,
    parameter int MAXLEN  = 16,
    parameter int CNTW    = 5,
    parameter int PKTW    = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PKTW:0]   i0,
    input  logic [PKTW:0]   i1,
    input  logic [PKTW:0]   i2,
    input  logic [PKTW:0]   i3,
    output logic [3:0]      ack,
    output logic [PKTW:0]   o,
    output logic [3:0]      grant,
    output logic            busy,
    output logic            err
);
    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

    localparam logic [1:0]      TY_HEAD  = 2'b10;
    localparam logic [1:0]      TY_TAIL  = 2'b11;
    localparam logic [1:0]      DST_ID   = 2'(PORT_ID);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXLEN - 1);

    state_t          r_state;
    logic [3:0]      r_grant;
    logic [PKTW:0]   r_o;
    logic            r_busy;
    logic            r_err;
    logic [1:0]      r_ptr;
    logic [CNTW-1:0] r_cnt;

    logic [PKTW:0]   w_in [4];
    logic [3:0]      w_req;
    logic            w_any;
    logic [1:0]      w_win;
    logic [1:0]      w_owner;
    logic [PKTW:0]   w_flit;
    logic            w_tail;
    logic            w_timeout;

    assign w_in[0] = i0;
    assign w_in[1] = i1;
    assign w_in[2] = i2;
    assign w_in[3] = i3;

    // Only a head addressed to this port requests; body, tail and empty flits never do.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
        w_req = '0;
        for (int n = 0; n < 4; n++) begin
            w_req[n] = (w_in[n][PKTW -: 2] == TY_HEAD) && (w_in[n][1:0] == DST_ID);
        end
    end

    // Round-robin pick: first requester scanning ptr, ptr+1, ... with natural 2-bit wrap.
    always_comb begin : winner_sel
        logic [1:0] w_idx;
        w_any = 1'b0;
        w_win = r_ptr;
        w_idx = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_any && w_req[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        case (r_grant)
            4'b0010: w_owner = 2'd1;
            4'b0100: w_owner = 2'd2;
            4'b1000: w_owner = 2'd3;
            default: w_owner = 2'd0;
        endcase
    end

    assign w_flit    = w_in[w_owner];
    assign w_tail    = (w_flit[PKTW -: 2] == TY_TAIL);
    assign w_timeout = (r_cnt == CNT_LAST);

    // The pop strobe is the grant itself while locked; empty flits popped here are bubbles.
    assign ack   = (rst && (r_state == LOCK)) ? r_grant : 4'b0000;
    assign o     = r_o;
    assign grant = r_grant;
    assign busy  = r_busy;
    assign err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_o     <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values regardless of order.
            r_err <= 1'b0;
            if (r_state == IDLE) begin
                r_o <= '0;
                if (w_any) begin
                    r_state <= LOCK;
                    r_grant <= 4'b0001 << w_win;
                    r_busy  <= 1'b1;
                    r_cnt   <= '0;
                end
            end else begin
                r_o <= w_flit;
                if (w_tail || w_timeout) begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= w_owner + 2'd1;
                    r_err   <= !w_tail;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/sw_out_arb.md
Name: sw_out_arb

Overview:
- Per-output-port arbiter and packet lock for the 4-port switch network.
- Watches the head flit presented by each of the 4 input buffers and grants one input whose head targets this port, using round-robin priority.
- Holds the grant (wormhole lock) from head through tail and forwards flits to a registered output.
- One instance per output port (PORT_ID 0..3).

Parameters:
- PORT_ID, 0: output port number this instance serves; matched against the head destination field.
- MAXLEN, 16: maximum locked cycles (head through tail) before a forced release.
- CNTW, 5: lock-cycle counter width; must satisfy 2^CNTW > MAXLEN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (`ASSERT = 0).
- i0, i1, i2, i3  in  `PKTW+1  front flit of each input buffer. Bits [`PKTW:`PKTW-1]: 00 empty, 10 head, 01 body, 11 tail. Head destination is in bits [1:0].
- ack  out  4  one-hot pop strobe; input n's flit is consumed this cycle.
- o  out  `PKTW+1  registered forwarded flit; 0 when idle.
- grant  out  4  registered one-hot owner of the port; 0 when idle.
- busy  out  1  1 while in state LOCK.
- err  out  1  one-cycle pulse on forced release (timeout).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, grant=0, o=0, busy=0, err=0, ptr=0, cnt=0.
  - ack=0 combinationally while rst is asserted.
- req[n] (combinational) = (type(in)==10) && (in[1:0]==PORT_ID).
  - Body, tail and empty flits never request.
  - Heads for other ports are ignored.
- IDLE:
  - ack=0; o<=0.
  - If any req is set: at the edge, state<=LOCK, grant<=onehot(winner), cnt<=0.
  - Winner is the first set req scanning ptr, ptr+1, ... mod 4.
  - The winning input must hold its head until it is acked.
- LOCK:
  - ack = grant, unmasked. An empty flit acked while locked is a bubble.
  - o <= flit of the granted input; an empty flit yields o=0.
  - cnt increments every locked cycle.
- Normal release: the acked flit has type 11.
  - At that edge: o<=tail, state<=IDLE, grant<=0, ptr<=(owner+1) mod 4.
- Forced release: cnt==MAXLEN-1 with no tail.
  - Same as normal release, and err<=1 for one cycle.
  - The flit acked in that cycle is still forwarded to o.
- A head (10) arriving from the owner while locked is forwarded as data. No relock; the counter is not reset.
- Latency:
  - Head present at edge k (IDLE) -> grant at k+1, head acked in cycle k+1, head on o after edge k+2.
  - Throughput is 1 flit per cycle while locked.
  - At least one IDLE cycle between consecutive packets (release bubble).
- Simultaneous requests: only the winner is granted; losers wait with ack=0 and keep their heads.
- Reset mid-packet: immediate return to IDLE, outputs 0, ptr=0. The partially forwarded packet is abandoned. Upstream flushing is not this block's job.
- busy = (state==LOCK), registered.

Test Plan:
- Single packet: PORT_ID=1, i0 presents 10_1001_0001, 01_..., 01_..., 11_1001_0010 on successive acks.
  - grant=0001 one edge after the head; ack[0] high 4 cycles.
  - o shows the 4 flits starting 2 cycles after the head; busy falls after the tail; ptr=1.
- Destination filter: PORT_ID=0, i0 head with dst=2 -> no grant, ack=0, o stays 0 for 20 cycles.
- Contention: PORT_ID=3; i0, i1, i2 all present heads to port 3 at once, ptr=0.
  - Grant order 0, 1, 2, each packet complete, with one IDLE cycle between packets.
  - Repeat with ptr=2: order 2, 0, 1.
- Bubbles: owner inserts two empty flits mid-packet.
  - o=0 on those cycles; the lock is held and release happens only on the tail.
- Timeout: MAXLEN=16; owner sends a head, then only bodies.
  - Forced release after 16 locked cycles; err pulses exactly 1 cycle; grant=0; the next requester is granted.
- Reset mid-packet: rst=0 asynchronously after the 2nd flit.
  - grant, o, busy and ack go to 0 immediately.
  - After rst=1, a fresh head to PORT_ID is granted normally with ptr=0.
